// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG block scheduler: output channel codes,
// output FSM state encoding and the in-flight token carried alongside the pipeline.
package jpeg_pkg;

  localparam int BLOCK_PIXELS = 64;

  localparam logic [1:0] CHAN_Y  = 2'd0;
  localparam logic [1:0] CHAN_CB = 2'd1;
  localparam logic [1:0] CHAN_CR = 2'd2;

  // Widest block index a token can carry; narrower indices are zero-extended.
  localparam int TOKEN_IDX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_Y,
    ST_SEND_CB,
    ST_SEND_CR
  } out_state_e;

  typedef struct packed {
    logic                       valid;
    logic [TOKEN_IDX_WIDTH-1:0] idx;
  } token_t;

endpackage

// File: rtl/jpeg_block_fifo.sv
// Synchronous FIFO of whole compressed blocks; head is a combinational read of
// the oldest entry so the output stage can select channels without a copy.
module jpeg_block_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop) rd_ptr_q <= bump(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides what is valid,
  // and leaving the wide array reset-free keeps it plain RAM-style flops.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The credit scheme in the scheduler makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!reset_n) push_i |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Admits 8x8 RGB blocks into a non-stallable fixed-latency pipeline only when output
// space is reserved, captures Y/Cb/Cr results and streams them out as three beats.
module jpeg_block_scheduler
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int INPUT_WIDTH  = 8,
  parameter int PIXEL_COUNT  = BLOCK_PIXELS,
  parameter int PIPE_LATENCY = 12,
  parameter int OUT_DEPTH    = 2,
  parameter int IDX_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_all,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] g_all,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] b_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] pipe_r,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] pipe_g,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] pipe_b,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  pipe_y,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  pipe_cb,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  pipe_cr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0]  out_data,
  output logic [1:0]                        out_chan,
  output logic                              out_last,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              busy
);

  localparam int COEF_W  = DATA_WIDTH * PIXEL_COUNT;
  localparam int ENTRY_W = 3 * COEF_W + IDX_WIDTH;
  localparam int CW      = $clog2(OUT_DEPTH + 1);
  localparam int UW      = CW + 1;

  token_t [PIPE_LATENCY:0] tok_q;
  token_t                  tok_in;
  logic [IDX_WIDTH-1:0]    next_idx_q;
  logic [CW-1:0]           inflight_q;
  logic [CW-1:0]           fifo_count;
  logic [UW-1:0]           credit_used;
  logic [ENTRY_W-1:0]      fifo_head;
  logic [COEF_W-1:0]       head_y, head_cb, head_cr;
  logic [IDX_WIDTH-1:0]    head_idx;
  logic [IDX_WIDTH-1:0]    capture_idx;
  logic                    accept, capture, pop, more_after_pop;
  out_state_e              state_q;

  // Credit counts only registered state, so in_ready never waits on in_valid.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready    = reset_n && enable && (credit_used < UW'(OUT_DEPTH));
  assign accept      = in_valid && in_ready;
  assign capture     = tok_q[PIPE_LATENCY].valid;
  assign capture_idx = IDX_WIDTH'(tok_q[PIPE_LATENCY].idx);
  assign busy        = (inflight_q != '0) || (fifo_count != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tok_in = '0;
    if (accept) begin
      tok_in.valid = 1'b1;
      tok_in.idx   = TOKEN_IDX_WIDTH'(next_idx_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_r     <= '0;
      pipe_g     <= '0;
      pipe_b     <= '0;
      tok_q      <= '0;
      next_idx_q <= '0;
      inflight_q <= '0;
    end else begin
      tok_q      <= {tok_q[PIPE_LATENCY-1:0], tok_in};
      inflight_q <= inflight_q + CW'(accept) - CW'(capture);
      if (accept) begin
        pipe_r     <= r_all;
        pipe_g     <= g_all;
        pipe_b     <= b_all;
        next_idx_q <= next_idx_q + IDX_WIDTH'(1);
      end
    end
  end

  jpeg_block_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (capture),
    .data_i  ({pipe_y, pipe_cb, pipe_cr, capture_idx}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign {head_y, head_cb, head_cr, head_idx} = fifo_head;

  assign pop            = (state_q == ST_SEND_CR) && out_ready;
  assign more_after_pop = (fifo_count > CW'(1)) || capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      out_chan  <= CHAN_Y;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (fifo_count != '0) begin
          state_q   <= ST_SEND_Y;
          out_valid <= 1'b1;
          out_chan  <= CHAN_Y;
          out_last  <= 1'b0;
        end
        ST_SEND_Y: if (out_ready) begin
          state_q  <= ST_SEND_CB;
          out_chan <= CHAN_CB;
        end
        ST_SEND_CB: if (out_ready) begin
          state_q  <= ST_SEND_CR;
          out_chan <= CHAN_CR;
          out_last <= 1'b1;
        end
        ST_SEND_CR: if (out_ready) begin
          out_chan  <= CHAN_Y;
          out_last  <= 1'b0;
          state_q   <= more_after_pop ? ST_SEND_Y : ST_IDLE;
          out_valid <= more_after_pop;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Beat payload is a mux over the FIFO head, so it holds while the head is not popped.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    if (out_valid) begin
      out_idx = head_idx;
      case (out_chan)
        CHAN_Y:  out_data = head_y;
        CHAN_CB: out_data = head_cb;
        default: out_data = head_cr;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Self-checking bench for jpeg_block_scheduler with a stub fixed-latency pipeline
// and a block-level reference model of the expected beat stream.
module tb_jpeg_block_scheduler;

  localparam int IW     = 8;
  localparam int DW     = 32;
  localparam int PC     = 64;
  localparam int PL     = 12;
  localparam int OD     = 2;
  localparam int IDXW   = 4;
  localparam int PIX_W  = IW * PC;
  localparam int COEF_W = DW * PC;

  typedef struct {
    logic [PIX_W-1:0] r, g, b;
  } blk_t;

  typedef struct {
    logic [1:0]        chan;
    logic              last;
    logic [IDXW-1:0]   idx;
    logic [COEF_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PIX_W-1:0]  r_all = '0, g_all = '0, b_all = '0;
  logic [PIX_W-1:0]  pipe_r, pipe_g, pipe_b;
  logic [COEF_W-1:0] pipe_y, pipe_cb, pipe_cr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [COEF_W-1:0] out_data;
  logic [1:0]        out_chan;
  logic              out_last;
  logic [IDXW-1:0]   out_idx;
  logic              busy;

  int checks = 0;
  int errors = 0;

  blk_t  acc_q[$];
  beat_t beat_q[$];
  blk_t  rec_blk;
  beat_t rec_beat;

  always #5 clk = ~clk;

  jpeg_block_scheduler #(
    .DATA_WIDTH  (DW),
    .INPUT_WIDTH (IW),
    .PIXEL_COUNT (PC),
    .PIPE_LATENCY(PL),
    .OUT_DEPTH   (OD),
    .IDX_WIDTH   (IDXW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .pipe_r(pipe_r), .pipe_g(pipe_g), .pipe_b(pipe_b),
    .pipe_y(pipe_y), .pipe_cb(pipe_cb), .pipe_cr(pipe_cr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .out_idx(out_idx), .busy(busy)
  );

  // Per-pixel channel transform; distinct tags per channel expose any channel swap.
  function automatic logic [COEF_W-1:0] stub_coef(input int chan, input logic [PIX_W-1:0] r,
                                                  input logic [PIX_W-1:0] g, input logic [PIX_W-1:0] b);
    logic [COEF_W-1:0] res;
    logic [7:0] rv, gv, bv;
    res = '0;
    for (int p = 0; p < PC; p++) begin
      rv = r[p*IW +: IW];
      gv = g[p*IW +: IW];
      bv = b[p*IW +: IW];
      case (chan)
        0:       res[p*DW +: DW] = {8'h59, rv, gv, bv};
        1:       res[p*DW +: DW] = {8'hCB, gv, bv, rv};
        default: res[p*DW +: DW] = {8'hC7, bv, rv, gv};
      endcase
    end
    return res;
  endfunction

  // Stub pipeline: output follows its inputs by exactly PL clock edges.
  logic [3*COEF_W-1:0] stub_q [PL];
  always @(posedge clk) begin
    stub_q[0] <= {stub_coef(0, pipe_r, pipe_g, pipe_b), stub_coef(1, pipe_r, pipe_g, pipe_b),
                  stub_coef(2, pipe_r, pipe_g, pipe_b)};
    for (int i = 1; i < PL; i++) stub_q[i] <= stub_q[i-1];
  end
  assign {pipe_y, pipe_cb, pipe_cr} = stub_q[PL-1];

  // Recorder: logs accepted blocks and handshaken beats at the quiet mid-cycle point.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        rec_blk.r = r_all; rec_blk.g = g_all; rec_blk.b = b_all;
        acc_q.push_back(rec_blk);
      end
      if (out_valid && out_ready) begin
        rec_beat.chan = out_chan; rec_beat.last = out_last;
        rec_beat.idx = out_idx; rec_beat.data = out_data;
        beat_q.push_back(rec_beat);
      end
    end
  end

  function automatic logic [PIX_W-1:0] rand_pix();
    logic [PIX_W-1:0] v;
    for (int w = 0; w < PIX_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: the k-th accepted block since reset yields beats Y,Cb,Cr with idx k mod 2^IDXW.
  function automatic int first_bad_beat();
    int k, c;
    for (int j = 0; j < beat_q.size(); j++) begin
      k = j / 3;
      c = j % 3;
      if (k >= acc_q.size()) return j;
      if (beat_q[j].chan !== 2'(c) || beat_q[j].last !== (c == 2) ||
          beat_q[j].idx !== IDXW'(k % (1 << IDXW)) ||
          beat_q[j].data !== stub_coef(c, acc_q[k].r, acc_q[k].g, acc_q[k].b))
        return j;
    end
    return -1;
  endfunction

  task automatic report_beat(input string name, input int j);
    logic [COEF_W-1:0] e;
    logic [31:0] e_lo, g_lo;
    int k;
    k = j / 3;
    e = (k < acc_q.size()) ? stub_coef(j % 3, acc_q[k].r, acc_q[k].g, acc_q[k].b) : '0;
    e_lo = e[31:0];
    g_lo = beat_q[j].data[31:0];
    $display("FAIL %s: beat %0d got chan %0d last %0b idx %0d data[31:0] %08h, expected chan %0d last %0b idx %0d data[31:0] %08h",
             name, j, beat_q[j].chan, beat_q[j].last, beat_q[j].idx, g_lo,
             j % 3, (j % 3) == 2, k % (1 << IDXW), e_lo);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; enable = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    acc_q.delete();
    beat_q.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && beat_q.size() < n; c++) tick();
    if (beat_q.size() >= n) ok = 1'b1;
  endtask

  task automatic check_stream(input string name, input int n_beats);
    int bad;
    checks++;
    if (beat_q.size() != n_beats) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, beat_q.size(), n_beats);
    end
    bad = first_bad_beat();
    checks++;
    if (bad != -1) begin
      errors++;
      report_beat(name, bad);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_chan !== 2'd0 || out_last !== 1'b0 || out_idx !== '0) begin
      errors++; $display("FAIL reset_out_fields: got chan %0d last %b idx %0d expected 0 0 0", out_chan, out_last, out_idx); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got nonzero expected 0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pipe_r !== '0 || pipe_g !== '0 || pipe_b !== '0) begin
      errors++; $display("FAIL reset_pipe: got nonzero expected 0"); end
  endtask

  task automatic test_single_block();
    logic [PIX_W-1:0] px;
    bit early;
    do_reset();
    px = {PC{8'h80}};
    enable = 1'b1; out_ready = 1'b1;
    r_all = px; g_all = px; b_all = px; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (pipe_r !== px || pipe_g !== px || pipe_b !== px) begin
      errors++; $display("FAIL single_pipe_in: got %02h expected 80", pipe_r[7:0]); end
    early = 1'b0;
    for (int k = 1; k <= PL + 1; k++) begin
      tick();
      if (out_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL single_early_valid: got out_valid before cycle %0d expected none", PL + 2); end
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(c) || out_last !== (c == 2) || out_idx !== '0 ||
          out_data !== stub_coef(c, px, px, px)) begin
        errors++;
        $display("FAIL single_beat%0d: got valid %b chan %0d last %b idx %0d expected 1 %0d %b 0",
                 c, out_valid, out_chan, out_last, out_idx, c, c == 2);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: got valid %b busy %b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_credit_stall();
    bit cr0_next, seen, early, back;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
      tick();
    end
    checks++; if (acc_q.size() != OD) begin errors++; $display("FAIL stall_accepts: got %0d expected %0d", acc_q.size(), OD); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    cr0_next = 1'b0; seen = 1'b0; early = 1'b0; back = 1'b0;
    for (int c = 0; c < 100 && beat_q.size() < 3 * OD; c++) begin
      tick();
      if (cr0_next) begin back = (in_ready === 1'b1); cr0_next = 1'b0; seen = 1'b1; end
      else if (!seen && in_ready !== 1'b0) early = 1'b1;
      if (out_valid && out_ready && out_chan == 2'd2 && out_idx == '0) cr0_next = 1'b1;
    end
    checks++; if (early || !back) begin
      errors++; $display("FAIL stall_credit_return: got early %b returned %b expected 0 1", early, back); end
    check_stream("stall_beats", 3 * OD);
  endtask

  task automatic test_back_to_back();
    bit prev_stall, stable;
    logic [1:0] p_chan; logic p_last; logic [IDXW-1:0] p_idx; logic [COEF_W-1:0] p_data;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    prev_stall = 1'b0; stable = 1'b1;
    p_chan = '0; p_last = 1'b0; p_idx = '0; p_data = '0;
    for (int c = 0; c < 400 && beat_q.size() < 12; c++) begin
      in_valid = (acc_q.size() < 4);
      r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
      out_ready = ~out_ready;
      prev_stall = out_valid && !out_ready;
      p_chan = out_chan; p_last = out_last; p_idx = out_idx; p_data = out_data;
      tick();
      if (prev_stall && (out_valid !== 1'b1 || out_chan !== p_chan || out_last !== p_last ||
                         out_idx !== p_idx || out_data !== p_data)) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (!stable) begin errors++; $display("FAIL b2b_stable: got changing outputs while stalled expected stable"); end
    check_stream("b2b_beats", 12);
  endtask

  task automatic test_index_wrap();
    bit ok;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 1000 && beat_q.size() < 51; c++) begin
      in_valid = (acc_q.size() < 17);
      r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
      tick();
    end
    in_valid = 1'b0;
    wait_beats(51, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d beats expected 51", beat_q.size()); end
    check_stream("wrap_beats", 51);
    if (beat_q.size() >= 51) begin
      checks++; if (beat_q[45].idx !== 4'd15 || beat_q[48].idx !== 4'd0) begin
        errors++; $display("FAIL wrap_idx: got %0d then %0d expected 15 then 0", beat_q[45].idx, beat_q[48].idx); end
    end
  endtask

  task automatic test_enable_drop();
    bit saw_cr, fell, busy_ok;
    do_reset();
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
    tick();
    enable = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready: got %b expected 0", in_ready); end
    saw_cr = 1'b0; fell = 1'b0; busy_ok = 1'b1;
    for (int c = 0; c < 60 && !fell; c++) begin
      tick();
      if (saw_cr) begin
        fell = 1'b1;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (out_valid && out_ready && out_chan == 2'd2) saw_cr = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++; if (!fell || !busy_ok) begin
      errors++; $display("FAIL en_busy: got done %b busy_ok %b expected 1 1", fell, busy_ok); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL en_accepts: got %0d expected 1", acc_q.size()); end
    check_stream("en_beats", 3);
  endtask

  task automatic test_reset_mid();
    bit found, quiet, ok;
    do_reset();
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
    tick();
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      in_valid = (c == 4);
      if (c == 4) begin r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix(); end
      tick();
      if (out_valid === 1'b1 && out_chan === 2'd1) found = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (!found || !busy) begin errors++; $display("FAIL rst_mid_reach_cb: got found %b busy %b expected 1 1", found, busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_last !== 1'b0 || out_idx !== '0 || out_data !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got valid %b chan %0d last %b idx %0d expected 0 0 0 0",
                         out_valid, out_chan, out_last, out_idx); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_status: got busy %b in_ready %b expected 0 0", busy, in_ready); end
    repeat (2) tick();
    acc_q.delete();
    beat_q.delete();
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet || beat_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d beats quiet %b expected 0 1", beat_q.size(), quiet); end
    in_valid = 1'b1;
    r_all = rand_pix(); g_all = rand_pix(); b_all = rand_pix();
    tick();
    in_valid = 1'b0;
    wait_beats(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got %0d beats expected 3", beat_q.size()); end
    check_stream("rst_mid_new", 3);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_credit_stall();
    test_back_to_back();
    test_index_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_block_scheduler.md
Name: jpeg_block_scheduler

Overview:
Sequences 8x8 RGB blocks into the fixed-latency, non-stallable jpeg_compression_pipeline_optimized datapath. Because that datapath cannot be stalled, this block admits a new block only when output buffer space is guaranteed (credit scheme). It tracks in-flight blocks with a token shift register and captures the Y/Cb/Cr zigzag results into an output FIFO. It then serialises each buffered block as three channel beats over a valid/ready stream toward the entropy coder.

Parameters:
DATA_WIDTH, 32, width of one coefficient
INPUT_WIDTH, 8, width of one RGB component
PIXEL_COUNT, 64, pixels per block
PIPE_LATENCY, 12, cycles from a pipe_* input change to the matching *_zigzag output; must equal the instantiated pipeline's latency; must be >= 1
OUT_DEPTH, 2, output FIFO depth in blocks; must be >= 1
IDX_WIDTH, 16, block index width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  admit new blocks when high; in-flight work drains regardless
in_valid  in  1  upstream block available
in_ready  out  1  scheduler accepts block this cycle
r_all/g_all/b_all  in  INPUT_WIDTH*PIXEL_COUNT each  upstream block
pipe_r/pipe_g/pipe_b  out  INPUT_WIDTH*PIXEL_COUNT each  registered pipeline inputs
pipe_y/pipe_cb/pipe_cr  in  DATA_WIDTH*PIXEL_COUNT each  pipeline zigzag outputs
out_valid  out  1  beat available
out_ready  in  1  downstream accepts beat
out_data  out  DATA_WIDTH*PIXEL_COUNT  coefficients of the current channel
out_chan  out  2  0=Y, 1=Cb, 2=Cr
out_last  out  1  high on the Cr beat
out_idx  out  IDX_WIDTH  block index of the beat
busy  out  1  in-flight count != 0 or FIFO not empty

Behaviour:
- Reset (async assert, sync release): pipe_* = 0, token register = 0, in-flight count = 0, FIFO empty, FSM = IDLE, next index = 0. Outputs: out_valid = 0, out_chan = 0, out_last = 0, out_idx = 0, out_data = 0, busy = 0, in_ready = 0 while reset is asserted.
- Credit rule: in_ready = enable && (inflight + fifo_count < OUT_DEPTH). The rule is combinational from registered counts only and does not depend on in_valid.
- Accept = in_valid && in_ready, at edge T:
  - pipe_* <= r/g/b_all. pipe_* holds its value until the next accept.
  - Token[0] <= {1, next_idx}; next_idx increments and wraps from 2^IDX_WIDTH-1 to 0.
  - Inflight increments.
- Token shift register: PIPE_LATENCY+1 stages of {valid, idx}, shifting every cycle. The token's appearance at the last stage coincides with the matching block on pipe_y/cb/cr.
- Capture: when the last stage is valid, push {pipe_y, pipe_cb, pipe_cr, idx} into the FIFO and decrement inflight. Accept at edge T produces capture at edge T+PIPE_LATENCY+1, and the Y beat is visible from edge T+PIPE_LATENCY+2 when the FIFO was empty and the FSM was IDLE.
- Simultaneous events:
  - Accept plus capture in the same cycle: inflight is unchanged.
  - Capture plus pop in the same cycle: fifo_count is unchanged.
  - The credit rule guarantees a capture never finds the FIFO full. Overflow is unreachable and is asserted in simulation.
- Output FSM states and transitions:
  - IDLE: out_valid = 0. Go to SEND_Y when the FIFO is non-empty.
  - SEND_Y: chan 0, out_data = head Y. On handshake go to SEND_CB.
  - SEND_CB: chan 1, out_data = head Cb. On handshake go to SEND_CR.
  - SEND_CR: chan 2, out_last = 1, out_data = head Cr. On handshake pop the head, then go to SEND_Y if the FIFO still holds a block after the pop, else go to IDLE.
  - out_data, out_chan, out_last and out_idx are stable while out_valid && !out_ready.
- enable low: in_ready = 0 immediately. Tokens keep shifting, captures and output continue.
- Reset mid-operation: in-flight tokens and buffered blocks are discarded, and no partial block is emitted after release.
- Data is passed through unmodified; no arithmetic on coefficients.

Decomposition:
- Shared package jpeg_pkg holds:
  - localparams BLOCK_PIXELS=64, CHAN_Y=0, CHAN_CB=1, CHAN_CR=2.
  - a typedef for the output FSM state enum.
  - a typedef for the token {valid, idx}.
- One sub-module: jpeg_block_fifo, a synchronous FIFO of OUT_DEPTH entries with push/pop/count/head. The FSM, credit logic and token register stay in the top level.

Test Plan:
- Single block: with out_ready=1, accept at cycle 0 with R=G=B=0x80 in all pixels → pipe_* = 0x80.. at cycle 1. out_valid rises at cycle PIPE_LATENCY+2 with idx 0, followed by chan 0,1,2 on consecutive cycles and out_last only on chan 2.
- Credit stall: with OUT_DEPTH=2, out_ready=0 and in_valid held → exactly 2 accepts, then in_ready=0 permanently. Raising out_ready → blocks 0 then 1 drain, and in_ready returns after block 0's Cr beat.
- Back-to-back with backpressure: 4 blocks with out_ready toggling 1010… → out_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3, data matching the stub pipeline, no loss, no duplicates, outputs stable while stalled.
- Index wrap: preload by issuing 65535 accepts (or use IDX_WIDTH=4 with 17 blocks) → index goes 15 then 0.
- enable drop: deassert enable one cycle after an accept → in_ready=0, and the in-flight block still emits 3 beats; busy falls one cycle after its Cr handshake.
- Reset mid-stream: assert reset_n=0 during SEND_CB with 1 block in flight → outputs go to their reset values immediately. After release no beats appear until a new accept, and the new block carries idx 0.
